snes_pad_scanner: RTL and testbench
===================================

SNES_PAD_SCANNER -- requirements
Module: snes_pad_scanner

Interface
REQ-001 Parameter NCHAN, default 2, number of pad data inputs sharing one latch/clock pair; legal range 1..4.
REQ-002 Parameter NBITS, default 16, bits shifted per scan (8 = NES, 16 = SNES); legal range 8..16.
REQ-003 Parameter HALFPER, default 288, clk6x cycles per NESCLOCK half-period (6 us at 48 MHz); legal range ≥2.
REQ-004 Parameter GAP, default 48000, idle clk6x cycles between autopoll scans (1 ms at 48 MHz); legal range ≥1.
REQ-005 clk6x  in  1  system clock, single clock domain.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 start_i  in  1  one-cycle scan request.
REQ-008 autopoll_i  in  1  level; enables periodic scanning.
REQ-009 nesdata_i  in  NCHAN  serial pad data, active-low, already synchronised.
REQ-010 irq_ack_i  in  1  one-cycle clear for irq_o.
REQ-011 NESLATCH  out  1  pad latch, active-high.
REQ-012 NESCLOCK  out  1  pad shift clock, idles high.
REQ-013 busy_o  out  1  scan in progress.
REQ-014 done_o  out  1  one-cycle pulse on scan completion.
REQ-015 buttons_o  out  NCHAN*NBITS  pressed=1; channel c occupies bits [c*NBITS +: NBITS], bit 0 = first shifted bit (B on SNES).
REQ-016 irq_o  out  1  button-change interrupt, level.

Function
REQ-017 FSM states SHALL be IDLE, LATCH, FIRST, CLKLO, CLKHI, DONE, WAIT.
REQ-018 IDLE -> LATCH on start_i=1, or on autopoll_i=1 when WAIT has expired; start_i while busy_o=1 SHALL be ignored, not queued.
REQ-019 LATCH: NESLATCH=1, NESCLOCK=1 for exactly 2*HALFPER cycles.
REQ-020 FIRST: NESLATCH=0, NESCLOCK=1 for HALFPER cycles; bit 0 of every channel SHALL be sampled on the last cycle.
REQ-021 CLKLO: NESCLOCK=0 for HALFPER cycles; then CLKHI: NESCLOCK=1 for HALFPER cycles, bit k sampled on the last CLKHI cycle; repeat for k=1..NBITS-1.
REQ-022 Total scan length SHALL be (2*NBITS+1)*HALFPER cycles from the LATCH entry cycle to the DONE cycle.
REQ-023 Samples SHALL be inverted (pressed=1) into a per-channel shift register; buttons_o SHALL update all channels atomically in DONE, never mid-scan.
REQ-024 DONE lasts one cycle: done_o=1, busy_o falls the following cycle; next state WAIT when autopoll_i=1, else IDLE.
REQ-025 WAIT counts GAP cycles then enters LATCH; autopoll_i falling in WAIT SHALL return to IDLE next cycle; start_i in WAIT SHALL enter LATCH immediately.
REQ-026 busy_o=1 in LATCH, FIRST, CLKLO, CLKHI, DONE; 0 in IDLE and WAIT.
REQ-027 Half-period counter width SHALL be $clog2(2*HALFPER+1); bit counter width $clog2(NBITS+1); GAP counter $clog2(GAP+1); no wrap beyond terminal count.

Reset
REQ-028 resetn=0 SHALL immediately force: state IDLE, NESLATCH=0, NESCLOCK=1, busy_o=0, done_o=0, buttons_o=0, irq_o=0, all counters and shift registers 0.
REQ-029 Reset mid-scan SHALL abandon the scan; buttons_o holds 0, no done_o pulse after release.
REQ-030 After resetn rises, no scan SHALL start until start_i or autopoll_i is seen.

Configuration
REQ-031 Macro SNESPAD_CHANGE_IRQ_EN defined: in DONE, if new buttons differ from the previous buttons_o, irq_o SHALL set the next cycle and hold until irq_ack_i=1; a set and an ack in the same cycle SHALL resolve to set.
REQ-032 Macro SNESPAD_CHANGE_IRQ_EN undefined: irq_o SHALL be constant 0, irq_ack_i ignored, no compare logic synthesised.

Verification (HALFPER=4, NBITS=16, NCHAN=2, GAP=10)
REQ-033 Reset then start_i pulse, nesdata_i[0] drives 16'hFFFE pattern (bit0 low) -> NESLATCH high 8 cycles, done_o at cycle 132, buttons_o[15:0]=16'h0001, buttons_o[31:16]=0.
REQ-034 Pad ch1 returns bits 0..11 low, 12..15 high -> buttons_o[31:16]=16'h0FFF; NESCLOCK shows exactly 15 falling edges per scan.
REQ-035 start_i pulsed at cycle 50 of an active scan -> ignored; exactly one done_o pulse.
REQ-036 autopoll_i held high -> successive LATCH entries 11 cycles after each DONE; deassert during WAIT -> IDLE, no further NESLATCH.
REQ-037 resetn low at cycle 70 of a scan -> outputs at reset values same cycle; no done_o after release.
REQ-038 With SNESPAD_CHANGE_IRQ_EN: two identical scans -> irq_o rises after the first only; differing third scan -> irq_o rises; irq_ack_i -> irq_o low next cycle.

Source files
------------

// File: rtl/snes_pad_scanner_if.sv
// Pad-side and host-side signals of the SNES/NES pad scanner.
// master = host/pad environment, slave = scanner.
interface snes_pad_scanner_if #(
  parameter int unsigned NCHAN = 2,
  parameter int unsigned NBITS = 16
);
  logic                   start_i;
  logic                   autopoll_i;
  logic [NCHAN-1:0]       nesdata_i;
  logic                   irq_ack_i;
  logic                   NESLATCH;
  logic                   NESCLOCK;
  logic                   busy_o;
  logic                   done_o;
  logic [NCHAN*NBITS-1:0] buttons_o;
  logic                   irq_o;

  modport master (
    output start_i, autopoll_i, nesdata_i, irq_ack_i,
    input  NESLATCH, NESCLOCK, busy_o, done_o, buttons_o, irq_o
  );

  modport slave (
    input  start_i, autopoll_i, nesdata_i, irq_ack_i,
    output NESLATCH, NESCLOCK, busy_o, done_o, buttons_o, irq_o
  );
endinterface

// File: rtl/snes_pad_scanner.sv
// Serial NES/SNES pad scanner: latches the pads, shifts NBITS per channel, optional autopoll.
// Optional button-change interrupt enabled by defining SNESPAD_CHANGE_IRQ_EN.
module snes_pad_scanner #(
  parameter int unsigned NCHAN   = 2,
  parameter int unsigned NBITS   = 16,
  parameter int unsigned HALFPER = 288,
  parameter int unsigned GAP     = 48000
) (
  input logic                clk6x,
  input logic                resetn,
  snes_pad_scanner_if.slave  bus
);

  localparam int unsigned HW = $clog2(2 * HALFPER + 1);
  localparam int unsigned BW = $clog2(NBITS + 1);
  localparam int unsigned GW = $clog2(GAP + 1);

  localparam logic [HW-1:0] LatchLast = HW'(2 * HALFPER - 1);
  localparam logic [HW-1:0] HalfLast  = HW'(HALFPER - 1);
  localparam logic [BW-1:0] BitLast   = BW'(NBITS - 1);
  localparam logic [GW-1:0] GapLast   = GW'(GAP - 1);

  typedef enum logic [2:0] {
    StIdle, StLatch, StFirst, StClkLo, StClkHi, StDone, StWait
  } state_e;

  state_e                        state_q, state_d;
  logic [HW-1:0]                 half_q, half_d;
  logic [BW-1:0]                 bit_q, bit_d;
  logic [GW-1:0]                 gap_q, gap_d;
  logic [NCHAN-1:0][NBITS-1:0]   sr_q, sr_d, sr_shift;
  logic [NCHAN*NBITS-1:0]        buttons_q, buttons_d;

  // New sample enters at the top so the first shifted bit ends up in bit 0.
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      sr_shift[c] = {~bus.nesdata_i[c], sr_q[c][NBITS-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    bit_d     = bit_q;
    gap_d     = '0;
    sr_d      = sr_q;
    buttons_d = buttons_q;
    unique case (state_q)
      StIdle: begin
        half_d = '0;
        bit_d  = '0;
        if (bus.start_i || bus.autopoll_i) state_d = StLatch;
      end
      StLatch: begin
        if (half_q == LatchLast) begin
          half_d  = '0;
          state_d = StFirst;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      StFirst: begin
        if (half_q == HalfLast) begin
          half_d  = '0;
          bit_d   = BW'(1);
          sr_d    = sr_shift;
          state_d = StClkLo;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      StClkLo: begin
        if (half_q == HalfLast) begin
          half_d  = '0;
          state_d = StClkHi;
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      StClkHi: begin
        if (half_q == HalfLast) begin
          half_d = '0;
          sr_d   = sr_shift;
          if (bit_q == BitLast) begin
            bit_d   = '0;
            state_d = StDone;
          end else begin
            bit_d   = bit_q + BW'(1);
            state_d = StClkLo;
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      StDone: begin
        buttons_d = sr_q;
        state_d   = bus.autopoll_i ? StWait : StIdle;
      end
      StWait: begin
        if (bus.start_i) begin
          state_d = StLatch;
        end else if (!bus.autopoll_i) begin
          state_d = StIdle;
        end else if (gap_q == GapLast) begin
          state_d = StLatch;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      half_q    <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      sr_q      <= '0;
      buttons_q <= '0;
    end else begin
      state_q   <= state_d;
      half_q    <= half_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      sr_q      <= sr_d;
      buttons_q <= buttons_d;
    end
  end

  // Pad-facing strobes decode straight from state so reset forces them at once.
  assign bus.NESLATCH  = (state_q == StLatch);
  assign bus.NESCLOCK  = (state_q != StClkLo);
  assign bus.busy_o    = (state_q != StIdle) && (state_q != StWait);
  assign bus.done_o    = (state_q == StDone);
  assign bus.buttons_o = buttons_q;

`ifdef SNESPAD_CHANGE_IRQ_EN
  logic irq_q, irq_d;
  logic change;

  assign change = (state_q == StDone) && (sr_q != buttons_q);

  // A new change wins over a same-cycle acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (change) begin
      irq_d = 1'b1;
    end else if (bus.irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus.irq_o = irq_q;
`else
  logic unused_irq_ack;
  assign unused_irq_ack = bus.irq_ack_i;
  assign bus.irq_o      = 1'b0;
`endif

endmodule

// File: tb/tb_snes_pad_scanner.sv
// Directed + randomized bench for snes_pad_scanner with a behavioural pad model.
module tb_snes_pad_scanner;
  localparam int unsigned NCHAN   = 2;
  localparam int unsigned NBITS   = 16;
  localparam int unsigned HALFPER = 4;
  localparam int unsigned GAP     = 10;
  localparam int SCAN_LEN = (2 * NBITS + 1) * HALFPER;

  logic clk6x;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  snes_pad_scanner_if #(.NCHAN(NCHAN), .NBITS(NBITS)) bus ();

  snes_pad_scanner #(
    .NCHAN(NCHAN), .NBITS(NBITS), .HALFPER(HALFPER), .GAP(GAP)
  ) dut (
    .clk6x (clk6x),
    .resetn(resetn),
    .bus   (bus)
  );

  initial begin
    clk6x = 1'b0;
    forever #5 clk6x = ~clk6x;
  end

  // Pad model: pressed buttons, output index reset by latch, advanced by rising clock.
  logic [NBITS-1:0] pad_btn [NCHAN];
  int   pidx = 0;
  logic pclk_prev = 1'b1;

  always @(negedge clk6x) begin
    if (bus.NESLATCH) pidx = 0;
    else if (bus.NESCLOCK && !pclk_prev) pidx = pidx + 1;
    pclk_prev = bus.NESCLOCK;
  end

  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      bus.nesdata_i[c] = (pidx < NBITS) ? ~pad_btn[c][pidx] : 1'b0;
    end
  end

  // Event monitor.
  int   cyc = 0;
  int   latch_q[$];
  int   done_q[$];
  int   falls = 0;
  int   falls_at_done = 0;
  int   latch_len = 0;
  int   mid_change = 0;
  logic prev_latch = 1'b0;
  logic prev_nclk = 1'b1;
  logic prev_done = 1'b0;
  logic prev_rstn = 1'b0;
  logic [NCHAN*NBITS-1:0] prev_btn = '0;

  always @(negedge clk6x) begin
    cyc = cyc + 1;
    if (bus.NESLATCH && !prev_latch) begin
      latch_q.push_back(cyc);
      falls = 0;
      latch_len = 0;
    end
    if (bus.NESLATCH) latch_len = latch_len + 1;
    if (!bus.NESCLOCK && prev_nclk) falls = falls + 1;
    if (bus.done_o) begin
      done_q.push_back(cyc);
      falls_at_done = falls;
    end
    if (resetn && prev_rstn && (bus.buttons_o != prev_btn) && !prev_done)
      mid_change = mid_change + 1;
    prev_latch = bus.NESLATCH;
    prev_nclk  = bus.NESCLOCK;
    prev_done  = bus.done_o;
    prev_rstn  = resetn;
    prev_btn   = bus.buttons_o;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk6x);
    #1;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.done_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_latch(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus.NESLATCH) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  logic [NCHAN*NBITS-1:0] model_btn = '0;

  // One requested scan; optional second start at 'mid' cycles into the scan.
  task automatic do_scan(input logic [NBITS-1:0] b0, input logic [NBITS-1:0] b1,
                         input int mid, input string tag);
    logic [NCHAN*NBITS-1:0] expb;
    logic exp_irq;
    bit   seen;
    int   nd, nl;
    pad_btn[0] = b0;
    pad_btn[1] = b1;
    expb = {b1, b0};
`ifdef SNESPAD_CHANGE_IRQ_EN
    exp_irq = (expb != model_btn);
`else
    exp_irq = 1'b0;
`endif
    model_btn = expb;
    nd = done_q.size();
    nl = latch_q.size();
    pulse_start();
    if (mid > 0) begin
      wait_latch(10, seen);
      check({tag, "_latch_seen"}, 64'(seen), 64'd1);
      for (int i = 0; i < mid; i++) tick();
      check({tag, "_busy_mid"}, 64'(bus.busy_o), 64'd1);
      pulse_start();
    end
    wait_done(SCAN_LEN + 20, seen);
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_scan_len"}, 64'(done_q[done_q.size()-1] - latch_q[latch_q.size()-1]),
          64'(SCAN_LEN));
    check({tag, "_latch_len"}, 64'(latch_len), 64'(2 * HALFPER));
    check({tag, "_clk_falls"}, 64'(falls_at_done), 64'(NBITS - 1));
    tick();
    check({tag, "_busy_after"}, 64'(bus.busy_o), 64'd0);
    check({tag, "_buttons"}, 64'(bus.buttons_o), 64'(expb));
    check({tag, "_irq"}, 64'(bus.irq_o), 64'(exp_irq));
    if (exp_irq) begin
      bus.irq_ack_i = 1'b1;
      tick();
      bus.irq_ack_i = 1'b0;
      check({tag, "_irq_ack"}, 64'(bus.irq_o), 64'd0);
    end
    for (int i = 0; i < 20; i++) tick();
    check({tag, "_one_done"}, 64'(done_q.size() - nd), 64'd1);
    check({tag, "_one_latch"}, 64'(latch_q.size() - nl), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_latch"}, 64'(bus.NESLATCH), 64'd0);
    check({tag, "_nesclk"}, 64'(bus.NESCLOCK), 64'd1);
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    check({tag, "_done"}, 64'(bus.done_o), 64'd0);
    check({tag, "_buttons"}, 64'(bus.buttons_o), 64'd0);
    check({tag, "_irq"}, 64'(bus.irq_o), 64'd0);
  endtask

  initial begin
    logic [NBITS-1:0] r0, r1;
    logic [NCHAN*NBITS-1:0] expb;
    bit seen;
    int nd, nl;

    resetn        = 1'b0;
    bus.start_i    = 1'b0;
    bus.autopoll_i = 1'b0;
    bus.irq_ack_i  = 1'b0;
    pad_btn[0]     = '0;
    pad_btn[1]     = '0;
    for (int i = 0; i < 4; i++) tick();
    check_reset_outputs("reset");

    resetn = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("no_scan_after_reset", 64'(latch_q.size()), 64'd0);

    // Raw ch0 16'hFFFE (only bit0 low) -> pressed 0x0001; ch1 all high -> 0.
    do_scan(16'h0001, 16'h0000, 0, "scan_a");
    // Ch1 bits 0..11 low -> 0x0FFF; a second start mid-scan must be dropped.
    do_scan(16'h0001, 16'h0FFF, 50, "scan_b");
    do_scan(16'h0001, 16'h0FFF, 0, "scan_same");
    for (int n = 0; n < 4; n++) begin
      r0 = 16'($urandom);
      r1 = 16'($urandom);
      do_scan(r0, r1, 0, "scan_rand");
    end
    do_scan(r0, r1, 0, "scan_rand_same");

    // Autopoll: LATCH re-entered GAP+1 cycles after each DONE.
    r0 = 16'($urandom);
    r1 = 16'($urandom);
    pad_btn[0] = r0;
    pad_btn[1] = r1;
    expb = {r1, r0};
    nd = done_q.size();
    nl = latch_q.size();
    bus.autopoll_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(SCAN_LEN + GAP + 20, seen);
      check("auto_done_seen", 64'(seen), 64'd1);
    end
    for (int i = 0; i < 3; i++) tick();
    bus.autopoll_i = 1'b0;
    for (int i = 0; i < 200; i++) tick();
    check("auto_gap0", 64'(latch_q[nl+1] - done_q[nd]), 64'(GAP + 1));
    check("auto_gap1", 64'(latch_q[nl+2] - done_q[nd+1]), 64'(GAP + 1));
    check("auto_stop_latches", 64'(latch_q.size() - nl), 64'd3);
    check("auto_stop_busy", 64'(bus.busy_o), 64'd0);
    check("auto_buttons", 64'(bus.buttons_o), 64'(expb));
    bus.irq_ack_i = 1'b1;
    tick();
    bus.irq_ack_i = 1'b0;

    // Reset 70 cycles into a scan.
    pad_btn[0] = 16'hA5A5;
    pad_btn[1] = 16'h5A5A;
    pulse_start();
    wait_latch(10, seen);
    check("rst_latch_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 70; i++) tick();
    resetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    nd = done_q.size();
    nl = latch_q.size();
    for (int i = 0; i < 3; i++) tick();
    resetn = 1'b1;
    for (int i = 0; i < SCAN_LEN + 20; i++) tick();
    check("rst_no_done", 64'(done_q.size() - nd), 64'd0);
    check("rst_no_latch", 64'(latch_q.size() - nl), 64'd0);
    check("rst_buttons_hold", 64'(bus.buttons_o), 64'd0);
    check("no_mid_scan_update", 64'(mid_change), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
